cache_ram_sched: RTL and testbench

CACHE_RAM_SCHED -- requirements
Module: cache_ram_sched

---
 rtl/cache_ram_pkg.sv | 13 +
 rtl/cache_ram_arb.sv | 47 ++++
 rtl/cache_ram_sched.sv | 149 ++++++++++++++
 tb/tb_cache_ram_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ram_pkg.sv
// rtl/cache_ram_pkg.sv - shared parameters and state type for the cache RAM scheduler
package cache_ram_pkg;

  localparam int IDX_W      = 7;    // set-index width (128 sets)
  localparam int DATA_W     = 128;  // line width per way
  localparam int STARVE_MAX = 4;    // max consecutive fill grants while a lookup waits

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cache_ram_arb.sv
// rtl/cache_ram_arb.sv - fill-over-lookup arbiter with lookup starvation guard
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_en            : grants allowed this cycle (RUN with sweep done, not in reset)
//   i_lk_req        : lookup request
//   i_fl_req        : fill request
//   o_lk_gnt        : lookup grant (combinational)
//   o_fl_gnt        : fill grant (combinational)
module cache_ram_arb
  import cache_ram_pkg::*;
#(
  parameter int STARVE_MAX = cache_ram_pkg::STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_lk_req,
  input  logic i_fl_req,
  output logic o_lk_gnt,
  output logic o_fl_gnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve_cnt;
  logic          w_starved;
  logic          w_lk_wins;

  assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));

  // Fill normally wins; a lookup that has watched STARVE_MAX fills go by takes the slot.
  assign w_lk_wins = i_lk_req && (!i_fl_req || w_starved);
  assign o_lk_gnt  = i_en && w_lk_wins;
  assign o_fl_gnt  = i_en && i_fl_req && !w_lk_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_lk_req || o_lk_gnt) begin
      r_starve_cnt <= '0;
    end else if (o_fl_gnt && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + {{(SW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/cache_ram_sched.sv
// rtl/cache_ram_sched.sv - schedules lookups and refills onto a 2-way single-port tag/data RAM
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   lk_req, lk_idx, lk_gnt         : lookup request / set index / grant
//   lk_rvalid, lk_rdata0/1         : lookup read data valid (grant + 2) and way0/way1 data
//   fl_req, fl_idx, fl_way,
//   fl_data, fl_bmask, fl_gnt      : refill write request (bmask 1 = write bit) / grant
//   ram_cen, ram_wen, ram_bwen     : RAM active-low chip, write and bit-write enables
//   ram_a, ram_d, ram_dsel         : RAM address, write data, write way select
//   ram_q0, ram_q1                 : RAM read data, valid one cycle after a read
//   init_done                      : clear sweep finished
module cache_ram_sched
  import cache_ram_pkg::*;
#(
  parameter int IDX_W      = cache_ram_pkg::IDX_W,
  parameter int DATA_W     = cache_ram_pkg::DATA_W,
  parameter int STARVE_MAX = cache_ram_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_req,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_gnt,
  output logic              lk_rvalid,
  output logic [DATA_W-1:0] lk_rdata0,
  output logic [DATA_W-1:0] lk_rdata1,
  input  logic              fl_req,
  input  logic [IDX_W-1:0]  fl_idx,
  input  logic              fl_way,
  input  logic [DATA_W-1:0] fl_data,
  input  logic [DATA_W-1:0] fl_bmask,
  output logic              fl_gnt,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_bwen,
  output logic [IDX_W-1:0]  ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_dsel,
  input  logic [DATA_W-1:0] ram_q0,
  input  logic [DATA_W-1:0] ram_q1,
  output logic              init_done
);

  state_t            r_state;
  logic [IDX_W:0]    r_cnt;
  logic              r_init_done;
  logic              r_rd_p1;
  logic              r_lk_rvalid;
  logic              r_ram_cen;
  logic              r_ram_wen;
  logic [DATA_W-1:0] r_ram_bwen;
  logic [IDX_W-1:0]  r_ram_a;
  logic [DATA_W-1:0] r_ram_d;
  logic              r_ram_dsel;

  logic              w_en;
  logic              w_lk_gnt;
  logic              w_fl_gnt;

  // The cycle after the last sweep write is already RUN but init_done is not yet
  // visible, so grants wait for init_done itself.
  assign w_en = (r_state == RUN) && r_init_done && !rst;

  cache_ram_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_lk_req (lk_req),
    .i_fl_req (fl_req),
    .o_lk_gnt (w_lk_gnt),
    .o_fl_gnt (w_fl_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_rd_p1     <= 1'b0;
      r_lk_rvalid <= 1'b0;
      r_ram_cen   <= 1'b1;
      r_ram_wen   <= 1'b1;
      r_ram_bwen  <= '1;
      r_ram_a     <= '0;
      r_ram_d     <= '0;
      r_ram_dsel  <= 1'b0;
    end else begin
      // Read pipeline: grant (N) -> RAM pins (N+1) -> RAM q valid (N+2).
      r_rd_p1     <= w_lk_gnt;
      r_lk_rvalid <= r_rd_p1;
      case (r_state)
        INIT: begin
          // Counter MSB walks the way select so both ways are cleared.
          r_ram_cen  <= 1'b0;
          r_ram_wen  <= 1'b0;
          r_ram_bwen <= '0;
          r_ram_a    <= r_cnt[IDX_W-1:0];
          r_ram_dsel <= r_cnt[IDX_W];
          r_ram_d    <= '0;
          r_cnt      <= r_cnt + {{IDX_W{1'b0}}, 1'b1};
          if (&r_cnt) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_init_done <= 1'b1;
          if (w_fl_gnt) begin
            r_ram_cen  <= 1'b0;
            r_ram_wen  <= 1'b0;
            r_ram_bwen <= ~fl_bmask;
            r_ram_a    <= fl_idx;
            r_ram_dsel <= fl_way;
            r_ram_d    <= fl_data;
          end else if (w_lk_gnt) begin
            r_ram_cen  <= 1'b0;
            r_ram_wen  <= 1'b1;
            r_ram_bwen <= '1;
            r_ram_a    <= lk_idx;
            r_ram_dsel <= 1'b0;
          end else begin
            r_ram_cen  <= 1'b1;
            r_ram_wen  <= 1'b1;
            r_ram_bwen <= '1;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  assign lk_gnt    = w_lk_gnt;
  assign fl_gnt    = w_fl_gnt;
  assign lk_rvalid = r_lk_rvalid;
  assign lk_rdata0 = ram_q0;
  assign lk_rdata1 = ram_q1;
  assign init_done = r_init_done;
  assign ram_cen   = r_ram_cen;
  assign ram_wen   = r_ram_wen;
  assign ram_bwen  = r_ram_bwen;
  assign ram_a     = r_ram_a;
  assign ram_d     = r_ram_d;
  assign ram_dsel  = r_ram_dsel;

endmodule

// File: tb/tb_cache_ram_sched.sv
// tb/tb_cache_ram_sched.sv - directed self-checking bench for cache_ram_sched
module tb_cache_ram_sched;

  localparam int IDX_W  = 7;
  localparam int DATA_W = 128;

  localparam logic [DATA_W-1:0] ONES    = '1;
  localparam logic [DATA_W-1:0] PAT_A5  = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_5A  = {16{8'h5A}};
  localparam logic [DATA_W-1:0] PAT_11  = {16{8'h11}};
  localparam logic [DATA_W-1:0] PAT_22  = {16{8'h22}};
  localparam logic [DATA_W-1:0] PAT_33  = {16{8'h33}};
  localparam logic [DATA_W-1:0] LO_MASK = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [DATA_W-1:0] HI_MASK = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

  logic              clk = 1'b0;
  logic              rst;
  logic              lk_req;
  logic [IDX_W-1:0]  lk_idx;
  logic              lk_gnt;
  logic              lk_rvalid;
  logic [DATA_W-1:0] lk_rdata0;
  logic [DATA_W-1:0] lk_rdata1;
  logic              fl_req;
  logic [IDX_W-1:0]  fl_idx;
  logic              fl_way;
  logic [DATA_W-1:0] fl_data;
  logic [DATA_W-1:0] fl_bmask;
  logic              fl_gnt;
  logic              ram_cen;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_bwen;
  logic [IDX_W-1:0]  ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_dsel;
  logic [DATA_W-1:0] ram_q0;
  logic [DATA_W-1:0] ram_q1;
  logic              init_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_ram_sched dut (
    .clk       (clk),
    .rst       (rst),
    .lk_req    (lk_req),
    .lk_idx    (lk_idx),
    .lk_gnt    (lk_gnt),
    .lk_rvalid (lk_rvalid),
    .lk_rdata0 (lk_rdata0),
    .lk_rdata1 (lk_rdata1),
    .fl_req    (fl_req),
    .fl_idx    (fl_idx),
    .fl_way    (fl_way),
    .fl_data   (fl_data),
    .fl_bmask  (fl_bmask),
    .fl_gnt    (fl_gnt),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_bwen  (ram_bwen),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_dsel  (ram_dsel),
    .ram_q0    (ram_q0),
    .ram_q1    (ram_q1),
    .init_done (init_done)
  );

  // Two-way single-port RAM with active-low bit write enables.
  logic [DATA_W-1:0] mem0 [1<<IDX_W];
  logic [DATA_W-1:0] mem1 [1<<IDX_W];

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) begin
        if (ram_dsel) mem1[ram_a] <= (mem1[ram_a] & ram_bwen) | (ram_d & ~ram_bwen);
        else          mem0[ram_a] <= (mem0[ram_a] & ram_bwen) | (ram_d & ~ram_bwen);
      end else begin
        ram_q0 <= mem0[ram_a];
        ram_q1 <= mem1[ram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Walks n sweep cycles, checking the write address sequence from 0.
  task automatic run_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      sample();
      chk($sformatf("sweep_pins[%0d]", i), {ram_cen, ram_wen, ram_dsel, ram_a},
          {1'b0, 1'b0, i[7], i[6:0]});
      chk($sformatf("sweep_bwen_d[%0d]", i), ram_bwen | ram_d, '0);
      chk($sformatf("sweep_flags[%0d]", i), {init_done, lk_gnt, fl_gnt, lk_rvalid}, 4'b0000);
    end
  endtask

  initial begin
    rst      = 1'b1;
    lk_req   = 1'b1;
    lk_idx   = '0;
    fl_req   = 1'b1;
    fl_idx   = '0;
    fl_way   = 1'b0;
    fl_data  = '0;
    fl_bmask = ONES;

    // Reset state, grants suppressed while rst is high.
    repeat (2) next_cycle();
    sample();
    chk("rst_cen_wen", {ram_cen, ram_wen}, 2'b11);
    chk("rst_bwen", ram_bwen, ONES);
    chk("rst_a_dsel", {ram_dsel, ram_a}, '0);
    chk("rst_d", ram_d, '0);
    chk("rst_flags", {init_done, lk_rvalid}, 2'b00);
    chk("rst_gnt", {lk_gnt, fl_gnt}, 2'b00);

    // Clear sweep with a lookup held throughout.
    fl_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    run_sweep(256);
    lk_req = 1'b0;
    next_cycle();
    sample();
    chk("init_done_after_sweep", init_done, 1'b1);
    chk("idle_after_sweep", {ram_cen, ram_wen, lk_gnt}, 3'b110);

    // Full-line fill to idx 5 way 1, then immediate lookup of the same index.
    next_cycle();
    fl_req = 1'b1; fl_idx = 7'd5; fl_way = 1'b1; fl_data = PAT_A5; fl_bmask = ONES;
    sample();
    chk("fill_gnt", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_req = 1'b0; lk_req = 1'b1; lk_idx = 7'd5;
    sample();
    chk("fill_pins", {ram_cen, ram_wen, ram_dsel, ram_a}, {3'b001, 7'd5});
    chk("fill_bwen", ram_bwen, '0);
    chk("fill_d", ram_d, PAT_A5);
    chk("lk_gnt_after_fill", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_req = 1'b0;
    sample();
    chk("read_pins", {ram_cen, ram_wen, ram_dsel, ram_a}, {3'b010, 7'd5});
    chk("read_bwen", ram_bwen, ONES);
    chk("rvalid_n1", lk_rvalid, 1'b0);
    next_cycle();
    sample();
    chk("rvalid_n2", lk_rvalid, 1'b1);
    chk("rdata1_a5", lk_rdata1, PAT_A5);
    chk("rdata0_zero", lk_rdata0, '0);
    next_cycle();
    sample();
    chk("rvalid_n3", lk_rvalid, 1'b0);

    // Simultaneous requests: fill first, lookup next.
    next_cycle();
    fl_req = 1'b1; fl_idx = 7'd9; fl_way = 1'b0; fl_data = PAT_5A;
    lk_req = 1'b1; lk_idx = 7'd5;
    sample();
    chk("contend_fill_first", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_req = 1'b0;
    sample();
    chk("contend_lk_next", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_req = 1'b0;
    sample();
    chk("no_req_no_gnt", {fl_gnt, lk_gnt}, 2'b00);

    // Starvation guard: four fills, then the lookup, then fills resume.
    next_cycle();
    fl_req = 1'b1; fl_idx = 7'd20; fl_way = 1'b1; fl_data = PAT_5A;
    lk_req = 1'b1; lk_idx = 7'd9;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("starve_fill[%0d]", k), {fl_gnt, lk_gnt}, 2'b10);
      next_cycle();
    end
    sample();
    chk("starve_lk_wins", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_req = 1'b0;
    sample();
    chk("fill_resume", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_req = 1'b0;
    sample();
    chk("starve_rvalid", lk_rvalid, 1'b1);
    chk("starve_rdata0", lk_rdata0, PAT_5A);

    // Partial bit mask: only the low half of the line is written.
    next_cycle();
    fl_req = 1'b1; fl_idx = 7'd7; fl_way = 1'b0; fl_data = ONES; fl_bmask = LO_MASK;
    sample();
    chk("mask_fill_gnt", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_req = 1'b0; fl_bmask = ONES; lk_req = 1'b1; lk_idx = 7'd7;
    sample();
    chk("mask_bwen", ram_bwen, HI_MASK);
    next_cycle();
    lk_req = 1'b0;
    next_cycle();
    sample();
    chk("mask_rvalid", lk_rvalid, 1'b1);
    chk("mask_rdata0", lk_rdata0, LO_MASK);

    // Back-to-back lookups of idx 1, 2, 3.
    next_cycle();
    fl_req = 1'b1; fl_idx = 7'd1; fl_way = 1'b0; fl_data = PAT_11;
    sample();
    chk("b2b_fill1", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_idx = 7'd2; fl_way = 1'b1; fl_data = PAT_22;
    sample();
    chk("b2b_fill2", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_idx = 7'd3; fl_way = 1'b0; fl_data = PAT_33;
    sample();
    chk("b2b_fill3", {fl_gnt, lk_gnt}, 2'b10);
    next_cycle();
    fl_req = 1'b0; lk_req = 1'b1; lk_idx = 7'd1;
    sample();
    chk("b2b_lk1", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_idx = 7'd2;
    sample();
    chk("b2b_lk2", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_idx = 7'd3;
    sample();
    chk("b2b_lk3", {fl_gnt, lk_gnt}, 2'b01);
    chk("b2b_rv1", {lk_rvalid, lk_rdata0, lk_rdata1} , {1'b1, PAT_11, {DATA_W{1'b0}}} );
    next_cycle();
    lk_req = 1'b0;
    sample();
    chk("b2b_rv2_valid", lk_rvalid, 1'b1);
    chk("b2b_rv2_d0", lk_rdata0, '0);
    chk("b2b_rv2_d1", lk_rdata1, PAT_22);
    next_cycle();
    sample();
    chk("b2b_rv3_valid", lk_rvalid, 1'b1);
    chk("b2b_rv3_d0", lk_rdata0, PAT_33);
    chk("b2b_rv3_d1", lk_rdata1, '0);
    next_cycle();
    sample();
    chk("b2b_rv_end", lk_rvalid, 1'b0);

    // Reset during an in-flight read: the rvalid must be dropped.
    next_cycle();
    lk_req = 1'b1; lk_idx = 7'd5;
    sample();
    chk("midread_lk_gnt", {fl_gnt, lk_gnt}, 2'b01);
    next_cycle();
    lk_req = 1'b0; rst = 1'b1; fl_req = 1'b1; fl_idx = 7'd30;
    sample();
    chk("gnt_in_rst", {fl_gnt, lk_gnt}, 2'b00);
    next_cycle();
    rst = 1'b0; fl_req = 1'b0;
    sample();
    chk("midread_rvalid_dropped", lk_rvalid, 1'b0);
    chk("midread_rst_state", {init_done, ram_cen, ram_wen}, 3'b011);

    // Reset pulsed mid-sweep: the sweep restarts from address 0, way 0.
    run_sweep(101);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    chk("midsweep_rst_pins", {init_done, ram_cen, ram_wen, ram_dsel, ram_a},
        {3'b011, 1'b0, 7'd0});
    run_sweep(256);
    next_cycle();
    sample();
    chk("resweep_init_done", init_done, 1'b1);
    chk("resweep_rvalid", lk_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
